// File: rtl/data_array_arbiter.sv
// +----------------------------------------------------------------------------+
// | data_array_arbiter                                                         |
// | N-channel data-array request arbiter with a registered valid/ready output. |
// | Build option: DATA_ARB_RR_EN selects round-robin instead of fixed priority.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_array_arbiter #(
  parameter int N_IN   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int WAYS   = 4,
  parameter logic [N_IN-1:0] WRITE_CH    = 4'b0011,
  parameter logic [N_IN-1:0] FULLMASK_CH = 4'b0010
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_IN-1:0]          io_in_valid,
  output logic [N_IN-1:0]          io_in_ready,
  input  logic [N_IN*ADDR_W-1:0]   io_in_bits_addr,
  input  logic [N_IN-1:0]          io_in_bits_write,
  input  logic [N_IN*DATA_W-1:0]   io_in_bits_wdata,
  input  logic [N_IN*MASK_W-1:0]   io_in_bits_eccMask,
  input  logic [N_IN*WAYS-1:0]     io_in_bits_way_en,
  input  logic                     io_out_ready,
  output logic                     io_out_valid,
  output logic [ADDR_W-1:0]        io_out_bits_addr,
  output logic                     io_out_bits_write,
  output logic [DATA_W-1:0]        io_out_bits_wdata,
  output logic [MASK_W-1:0]        io_out_bits_eccMask,
  output logic [WAYS-1:0]          io_out_bits_way_en
);

  localparam int GNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic              w_stage_free;
  logic              w_any_valid;
  logic              w_accept;
  logic [GNT_W-1:0]  w_grant;

  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_write;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [MASK_W-1:0] w_sel_mask;
  logic [WAYS-1:0]   w_sel_way;

  logic              w_nxt_write;
  logic [MASK_W-1:0] w_nxt_mask;
  logic [WAYS-1:0]   w_nxt_way;

  logic              r_out_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_mask;
  logic [WAYS-1:0]   r_way;

  assign w_stage_free = !r_out_valid || io_out_ready;
  assign w_any_valid  = |io_in_valid;
  assign w_accept     = w_stage_free && w_any_valid;

`ifdef DATA_ARB_RR_EN
  logic [GNT_W-1:0] r_ptr;

  // Channel index at priority rank 'off' when rank 0 is 'base', modulo N_IN.
  function automatic logic [GNT_W-1:0] f_wrap_add(input logic [GNT_W-1:0] base,
                                                  input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_IN) s = s - N_IN;
    return GNT_W'(s);
  endfunction

  // Scan from lowest rank to highest so the top-ranked valid channel wins last.
  always_comb begin
    w_grant = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (io_in_valid[f_wrap_add(r_ptr, k)]) w_grant = f_wrap_add(r_ptr, k);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= f_wrap_add(w_grant, 1);
    end
  end
`else
  always_comb begin
    w_grant = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (io_in_valid[k]) w_grant = GNT_W'(k);
    end
  end
`endif

  // Ready is gated by the channel's own valid only; never by its payload.
  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_ready
      assign io_in_ready[i] = w_stage_free && io_in_valid[i] &&
                              (w_grant == GNT_W'(i));
    end
  endgenerate

  always_comb begin
    w_sel_addr  = '0;
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    w_sel_mask  = '0;
    w_sel_way   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_grant == GNT_W'(i)) begin
        w_sel_addr  = io_in_bits_addr[i*ADDR_W +: ADDR_W];
        w_sel_write = io_in_bits_write[i];
        w_sel_wdata = io_in_bits_wdata[i*DATA_W +: DATA_W];
        w_sel_mask  = io_in_bits_eccMask[i*MASK_W +: MASK_W];
        w_sel_way   = io_in_bits_way_en[i*WAYS +: WAYS];
      end
    end
  end

  // Read-only channels cannot write and always enable every way.
  always_comb begin
    w_nxt_write = WRITE_CH[w_grant] ? w_sel_write : 1'b0;
    w_nxt_way   = WRITE_CH[w_grant] ? w_sel_way   : {WAYS{1'b1}};
    w_nxt_mask  = FULLMASK_CH[w_grant] ? {MASK_W{1'b1}} : w_sel_mask;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_way       <= '0;
    end else if (w_stage_free) begin
      r_out_valid <= w_any_valid;
      if (w_any_valid) begin
        r_addr  <= w_sel_addr;
        r_write <= w_nxt_write;
        r_wdata <= w_sel_wdata;
        r_mask  <= w_nxt_mask;
        r_way   <= w_nxt_way;
      end
    end
  end

  assign io_out_valid        = r_out_valid;
  assign io_out_bits_addr    = r_addr;
  assign io_out_bits_write   = r_write;
  assign io_out_bits_wdata   = r_wdata;
  assign io_out_bits_eccMask = r_mask;
  assign io_out_bits_way_en  = r_way;

endmodule

`default_nettype wire

// File: tb/tb_data_array_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_data_array_arbiter                                                      |
// | Randomized bench for data_array_arbiter with a behavioural reference model.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_array_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int WW = 4;
  localparam logic [N-1:0] C_WRITE_CH    = 4'b0011;
  localparam logic [N-1:0] C_FULLMASK_CH = 4'b0010;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*AW-1:0] in_addr;
  logic [N-1:0]    in_write;
  logic [N*DW-1:0] in_wdata;
  logic [N*MW-1:0] in_mask;
  logic [N*WW-1:0] in_way;
  logic            out_ready;
  logic            out_valid;
  logic [AW-1:0]   out_addr;
  logic            out_write;
  logic [DW-1:0]   out_wdata;
  logic [MW-1:0]   out_mask;
  logic [WW-1:0]   out_way;

  data_array_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .io_in_valid         (in_valid),
    .io_in_ready         (in_ready),
    .io_in_bits_addr     (in_addr),
    .io_in_bits_write    (in_write),
    .io_in_bits_wdata    (in_wdata),
    .io_in_bits_eccMask  (in_mask),
    .io_in_bits_way_en   (in_way),
    .io_out_ready        (out_ready),
    .io_out_valid        (out_valid),
    .io_out_bits_addr    (out_addr),
    .io_out_bits_write   (out_write),
    .io_out_bits_wdata   (out_wdata),
    .io_out_bits_eccMask (out_mask),
    .io_out_bits_way_en  (out_way)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the single output slot plus the priority start index.
  bit            m_valid;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_mask;
  logic [WW-1:0] m_way;
  int            m_ptr;
  logic [N-1:0]  last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [AW-1:0] a, input logic w,
                                       input logic [DW-1:0] d, input logic [MW-1:0] m,
                                       input logic [WW-1:0] way);
    return 64'({a, w, d, m, way});
  endfunction

  // First valid channel scanning from m_ptr upward, wrapping; -1 if none.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_ch(input int c, input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m, input logic [WW-1:0] way);
    in_valid[c]           = v;
    in_write[c]           = w;
    in_addr[c*AW +: AW]   = a;
    in_wdata[c*DW +: DW]  = d;
    in_mask[c*MW +: MW]   = m;
    in_way[c*WW +: WW]    = way;
  endtask

  task automatic check_out(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, "_bits"}, pack(out_addr, out_write, out_wdata, out_mask, out_way),
          pack(m_addr, m_write, m_wdata, m_mask, m_way));
  endtask

  // One cycle: check ready against the model, advance the model, clock, check output.
  task automatic step(input string tag);
    logic [N-1:0] exp_rdy;
    int g;
    bit free;
    #1;
    free    = !m_valid || out_ready;
    g       = model_grant();
    exp_rdy = '0;
    if (free && g >= 0) exp_rdy[g] = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(exp_rdy));
    last_acc = exp_rdy;
    if (free) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_addr  = in_addr[g*AW +: AW];
        m_wdata = in_wdata[g*DW +: DW];
        m_write = C_WRITE_CH[g] ? in_write[g] : 1'b0;
        m_way   = C_WRITE_CH[g] ? in_way[g*WW +: WW] : '1;
        m_mask  = C_FULLMASK_CH[g] ? '1 : in_mask[g*MW +: MW];
`ifdef DATA_ARB_RR_EN
        m_ptr   = (g + 1) % N;
`endif
      end
    end
    @(posedge clock);
    #1;
    check_out(tag);
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    m_valid = 0; m_addr = '0; m_write = 0; m_wdata = '0; m_mask = '0; m_way = '0;
    m_ptr = 0; last_acc = '0;
    check_out(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_write = '0; in_addr = '0; in_wdata = '0; in_mask = '0; in_way = '0;
  endtask

  task automatic all_valid_unique();
    for (int c = 0; c < N; c++)
      set_ch(c, 1'b1, 1'b1, AW'(12'h100 + c), DW'(c * 32'h1111_1111), MW'(c), WW'(1 << c));
  endtask

  int exp_seq[6];

  initial begin
    clear_inputs();
    out_ready = 1'b1;
    reset     = 1'b0;
    #2;
    do_reset("reset");

    // All channels valid continuously.
`ifdef DATA_ARB_RR_EN
    exp_seq = '{0, 1, 2, 3, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    all_valid_unique();
    for (int i = 0; i < 6; i++) begin
      step("allvalid");
      check("seq_addr", 64'(out_addr), 64'(12'h100 + exp_seq[i]));
    end

`ifdef DATA_ARB_RR_EN
    // Pointer now at 2; channel 2 drops out, so channel 3 must win.
    set_ch(2, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 4'h0);
    step("rr_skip");
    check("rr_skip_addr", 64'(out_addr), 64'(12'h103));
`endif

    // Read-only channel: write and way_en forced.
    clear_inputs();
    set_ch(2, 1'b1, 1'b1, 12'h0A5, 32'hCAFE_F00D, 4'h3, 4'b0010);
    step("ch2");
    check("ch2_valid", 64'(out_valid), 64'd1);
    check("ch2_addr",  64'(out_addr),  64'h0A5);
    check("ch2_write", 64'(out_write), 64'd0);
    check("ch2_way",   64'(out_way),   64'hF);
    check("ch2_mask",  64'(out_mask),  64'h3);

    // Full-mask writer channel.
    clear_inputs();
    set_ch(1, 1'b1, 1'b1, 12'h3C3, 32'h1234_5678, 4'h1, 4'b0100);
    step("ch1");
    check("ch1_mask",  64'(out_mask),  64'hF);
    check("ch1_write", 64'(out_write), 64'd1);
    check("ch1_way",   64'(out_way),   64'h4);

    // No valid: output empties, bits hold.
    clear_inputs();
    step("idle");

    // Stall with channels 0 and 3 pending.
    set_ch(0, 1'b1, 1'b1, 12'h011, 32'hAAAA_0000, 4'h5, 4'h1);
    set_ch(3, 1'b1, 1'b0, 12'h333, 32'hBBBB_3333, 4'h6, 4'h8);
    step("stall_load");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step("stall_release");
`ifndef DATA_ARB_RR_EN
    check("release_addr", 64'(out_addr), 64'h011);
`endif

    // Reset while a request is held and stalled.
    out_ready = 1'b0;
    step("pre_reset");
    do_reset("mid_reset");
    out_ready = 1'b1;
    all_valid_unique();
    step("post_reset");
    check("post_reset_addr", 64'(out_addr), 64'h100);

    // Randomized traffic honouring the hold-until-ready rule.
    for (int i = 0; i < 4000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) begin
        if (!(in_valid[c] && !last_acc[c])) begin
          set_ch(c, 1'($urandom_range(0, 1)), 1'($urandom), AW'($urandom),
                 DW'($urandom), MW'($urandom), WW'($urandom));
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand_reset");
      end
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
